// File: rtl/sau_pipe.sv
// Two-stage valid/ready pipeline multiplying each sample by every odd-row
// IntDCT coefficient for the configured transform size. Products use only
// shifts and adds on a small set of shared partials, followed by optional
// negation, round-half-up right shift and signed saturation.
module sau_pipe #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 24,
  parameter int unsigned DIM       = 8,
  parameter int unsigned SHIFT     = 0
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IN_WIDTH-1:0]            in_val,
  input  logic                           in_neg,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [(DIM/2)*OUT_WIDTH-1:0]   out_prod,
  output logic                           out_sat
);

  localparam int unsigned NCOEF = DIM / 2;
  // Largest coefficient is 90 < 2^7, so 8 extra bits hold any product and its negation.
  localparam int unsigned PW    = IN_WIDTH + 8;

  if (!(DIM == 4 || DIM == 8 || DIM == 16)) begin : g_bad_dim
    $fatal(1, "sau_pipe: DIM must be 4, 8 or 16");
  end
  if (SHIFT > 15) begin : g_bad_shift
    $fatal(1, "sau_pipe: SHIFT must be in 0..15");
  end

  // Handshake: a stage advances when it is empty or the stage after it advances.
  logic s1_valid_q, s2_valid_q;
  logic adv1, adv2;

  assign adv2      = !s2_valid_q || out_ready;
  assign adv1      = !s1_valid_q || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid_q;

  // Stage 1 partials: x, 3x, 5x, 9x, 25x, shared by all coefficient products.
  logic signed [PW-1:0] x_d, x3_d, x5_d, x9_d, x25_d;
  logic signed [PW-1:0] x_q, x3_q, x5_q, x9_q, x25_q;
  logic                 neg_q;

  // Sign-extend the sample and form the shared partials.
  always_comb begin
    x_d   = {{8{in_val[IN_WIDTH-1]}}, in_val};
    x3_d  = (x_d <<< 1) + x_d;
    x5_d  = (x_d <<< 2) + x_d;
    x9_d  = (x_d <<< 3) + x_d;
    x25_d = (x_d <<< 4) + x9_d;
  end

  // Stage 1 register: captures sample, negate flag and partials on acceptance.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s1_valid_q <= 1'b0;
      neg_q      <= 1'b0;
      x_q        <= '0;
      x3_q       <= '0;
      x5_q       <= '0;
      x9_q       <= '0;
      x25_q      <= '0;
    end else if (adv1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        neg_q <= in_neg;
        x_q   <= x_d;
        x3_q  <= x3_d;
        x5_q  <= x5_d;
        x9_q  <= x9_d;
        x25_q <= x25_d;
      end
    end
  end

  // Coefficient products from the partials, slice 0 first.
  logic signed [PW-1:0] cprod [NCOEF];

  if (DIM == 4) begin : g_dim4
    assign cprod[0] = (x25_q <<< 1) + (x9_q <<< 2) - x3_q;  // 83 = 50 + 36 - 3
    assign cprod[1] = (x5_q <<< 3) - (x_q <<< 2);           // 36 = 40 - 4
  end else if (DIM == 8) begin : g_dim8
    assign cprod[0] = (x_q <<< 6) + x25_q;                  // 89 = 64 + 25
    assign cprod[1] = (x9_q <<< 3) + x3_q;                  // 75 = 72 + 3
    assign cprod[2] = (x5_q <<< 3) + (x5_q <<< 1);          // 50 = 40 + 10
    assign cprod[3] = x9_q <<< 1;                           // 18
  end else begin : g_dim16
    assign cprod[0] = (x5_q <<< 4) + (x5_q <<< 1);          // 90 = 80 + 10
    assign cprod[1] = (x3_q <<< 5) - x9_q;                  // 87 = 96 - 9
    assign cprod[2] = x5_q <<< 4;                           // 80
    assign cprod[3] = (x_q <<< 6) + (x3_q <<< 1);           // 70 = 64 + 6
    assign cprod[4] = (x3_q <<< 4) + x9_q;                  // 57 = 48 + 9
    assign cprod[5] = x25_q + (x9_q <<< 1);                 // 43 = 25 + 18
    assign cprod[6] = x25_q;                                // 25
    assign cprod[7] = x9_q;                                 // 9
  end

  // Per-slice negate, round, saturate.
  logic [NCOEF-1:0]           sat_vec;
  logic [NCOEF*OUT_WIDTH-1:0] prod_d;

  for (genvar k = 0; k < NCOEF; k++) begin : g_slice
    logic signed [PW-1:0] p, r;

    assign p = neg_q ? -cprod[k] : cprod[k];

    if (SHIFT > 0) begin : g_rnd
      localparam logic signed [PW-1:0] Half = PW'(1) << (SHIFT - 1);
      assign r = (p + Half) >>> SHIFT;
    end else begin : g_nornd
      assign r = p;
    end

    if (OUT_WIDTH >= PW) begin : g_ext
      assign prod_d[k*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(r);
      assign sat_vec[k]                       = 1'b0;
    end else begin : g_clip
      // Value fits iff all bits from the output sign bit upward agree.
      logic [PW-OUT_WIDTH:0] hi;
      logic                  ovf;
      assign hi  = r[PW-1:OUT_WIDTH-1];
      assign ovf = !((&hi) || !(|hi));
      assign prod_d[k*OUT_WIDTH +: OUT_WIDTH] =
          !ovf    ? r[OUT_WIDTH-1:0] :
          r[PW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                    {1'b0, {(OUT_WIDTH-1){1'b1}}};
      assign sat_vec[k] = ovf;
    end
  end

  logic [NCOEF*OUT_WIDTH-1:0] prod_q;
  logic                       sat_q;

  // Stage 2 register: holds the finished beat until downstream takes it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s2_valid_q <= 1'b0;
      prod_q     <= '0;
      sat_q      <= 1'b0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        prod_q <= prod_d;
        sat_q  <= |sat_vec;
      end
    end
  end

  assign out_prod = prod_q;
  assign out_sat  = sat_q;

endmodule

// File: tb/tb_sau_pipe.sv
// Directed bench for sau_pipe: several parameterisations share one stimulus stream.
module tb_sau_pipe;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_neg = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_val = '0;

  logic rdy_a, rdy_b, rdy_c, rdy_d, rdy_e;
  logic vld_a, vld_b, vld_c, vld_d, vld_e;
  logic sat_a, sat_b, sat_c, sat_d, sat_e;
  logic [95:0]  prod_a, prod_b;
  logic [63:0]  prod_c;
  logic [191:0] prod_d;
  logic [47:0]  prod_e;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 HCLK = ~HCLK;

  // a: DIM8/24/shift0, b: shift2, c: 16-bit out, d: DIM16, e: DIM4
  sau_pipe #(.IN_WIDTH(16), .OUT_WIDTH(24), .DIM(8), .SHIFT(0)) u_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .in_valid(in_valid), .in_ready(rdy_a), .in_val(in_val),
    .in_neg(in_neg), .out_valid(vld_a), .out_ready(out_ready), .out_prod(prod_a),
    .out_sat(sat_a));
  sau_pipe #(.IN_WIDTH(16), .OUT_WIDTH(24), .DIM(8), .SHIFT(2)) u_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .in_valid(in_valid), .in_ready(rdy_b), .in_val(in_val),
    .in_neg(in_neg), .out_valid(vld_b), .out_ready(out_ready), .out_prod(prod_b),
    .out_sat(sat_b));
  sau_pipe #(.IN_WIDTH(16), .OUT_WIDTH(16), .DIM(8), .SHIFT(0)) u_c (
    .HCLK(HCLK), .HRESETn(HRESETn), .in_valid(in_valid), .in_ready(rdy_c), .in_val(in_val),
    .in_neg(in_neg), .out_valid(vld_c), .out_ready(out_ready), .out_prod(prod_c),
    .out_sat(sat_c));
  sau_pipe #(.IN_WIDTH(16), .OUT_WIDTH(24), .DIM(16), .SHIFT(0)) u_d (
    .HCLK(HCLK), .HRESETn(HRESETn), .in_valid(in_valid), .in_ready(rdy_d), .in_val(in_val),
    .in_neg(in_neg), .out_valid(vld_d), .out_ready(out_ready), .out_prod(prod_d),
    .out_sat(sat_d));
  sau_pipe #(.IN_WIDTH(16), .OUT_WIDTH(24), .DIM(4), .SHIFT(0)) u_e (
    .HCLK(HCLK), .HRESETn(HRESETn), .in_valid(in_valid), .in_ready(rdy_e), .in_val(in_val),
    .in_neg(in_neg), .out_valid(vld_e), .out_ready(out_ready), .out_prod(prod_e),
    .out_sat(sat_e));

  function automatic logic [95:0] pk24x4(input int a, input int b, input int c, input int d);
    return {24'(d), 24'(c), 24'(b), 24'(a)};
  endfunction

  function automatic logic [63:0] pk16x4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  // Presents one beat with out_ready=1; reports in_ready at presentation and
  // out_valid one and two cycles later. Returns with the beat on the outputs.
  task automatic run_beat(input int v, input logic neg,
                          output logic rdy0, output logic vld1, output logic vld2);
    @(negedge HCLK);
    in_valid  = 1'b1;
    in_val    = 16'(v);
    in_neg    = neg;
    out_ready = 1'b1;
    #1 rdy0 = rdy_a;
    @(negedge HCLK);
    in_valid = 1'b0;
    in_val   = 16'hDEAD;  // junk while idle must not reach the outputs
    in_neg   = ~neg;
    vld1     = vld_a;
    @(negedge HCLK);
    vld2 = vld_a;
  endtask

  task automatic test_reset();
    #2 HRESETn = 1'b0;
    #10;
    n_cmp++;
    if ({vld_a, vld_b, vld_c, vld_d, vld_e} !== 5'b0) begin
      n_bad++; $display("FAIL reset_valid: got %b want 00000", {vld_a, vld_b, vld_c, vld_d, vld_e});
    end
    n_cmp++;
    if ({prod_a, prod_b, prod_c, prod_d, prod_e} !== '0) begin
      n_bad++; $display("FAIL reset_prod: got a=%h d=%h want 0", prod_a, prod_d);
    end
    n_cmp++;
    if ({sat_a, sat_b, sat_c, sat_d, sat_e} !== 5'b0) begin
      n_bad++; $display("FAIL reset_sat: got %b want 00000", {sat_a, sat_b, sat_c, sat_d, sat_e});
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    n_cmp++;
    if ({rdy_a, rdy_b, rdy_c, rdy_d, rdy_e} !== 5'b11111) begin
      n_bad++; $display("FAIL reset_ready: got %b want 11111", {rdy_a, rdy_b, rdy_c, rdy_d, rdy_e});
    end
  endtask

  task automatic test_basic();
    logic r0, v1, v2;
    run_beat(1, 1'b0, r0, v1, v2);
    n_cmp++;
    if ({r0, v1, v2} !== 3'b101) begin
      n_bad++; $display("FAIL basic_latency: got rdy/v1/v2=%b want 101", {r0, v1, v2});
    end
    n_cmp++;
    if (prod_a !== pk24x4(89, 75, 50, 18) || sat_a !== 1'b0) begin
      n_bad++; $display("FAIL basic_dim8: got %h sat %b want %h sat 0",
                        prod_a, sat_a, pk24x4(89, 75, 50, 18));
    end
    n_cmp++;
    if (prod_b !== pk24x4(22, 19, 13, 5)) begin
      n_bad++; $display("FAIL basic_shift2: got %h want %h", prod_b, pk24x4(22, 19, 13, 5));
    end
    n_cmp++;
    if (prod_c !== pk16x4(89, 75, 50, 18) || sat_c !== 1'b0) begin
      n_bad++; $display("FAIL basic_out16: got %h sat %b want %h sat 0",
                        prod_c, sat_c, pk16x4(89, 75, 50, 18));
    end
    n_cmp++;
    if (prod_d !== {pk24x4(57, 43, 25, 9), pk24x4(90, 87, 80, 70)}) begin
      n_bad++; $display("FAIL basic_dim16: got %h want %h", prod_d,
                        {pk24x4(57, 43, 25, 9), pk24x4(90, 87, 80, 70)});
    end
    n_cmp++;
    if (prod_e !== {24'd36, 24'd83}) begin
      n_bad++; $display("FAIL basic_dim4: got %h want %h", prod_e, {24'd36, 24'd83});
    end
  endtask

  task automatic test_min_input();
    logic r0, v1, v2;
    run_beat(-32768, 1'b0, r0, v1, v2);
    n_cmp++;
    if (v2 !== 1'b1 || prod_a !== pk24x4(-2916352, -2457600, -1638400, -589824)
        || sat_a !== 1'b0) begin
      n_bad++; $display("FAIL min_pos: got %h sat %b want %h sat 0", prod_a, sat_a,
                        pk24x4(-2916352, -2457600, -1638400, -589824));
    end
    run_beat(-32768, 1'b1, r0, v1, v2);
    n_cmp++;
    if (v2 !== 1'b1 || prod_a !== pk24x4(2916352, 2457600, 1638400, 589824)
        || sat_a !== 1'b0) begin
      n_bad++; $display("FAIL min_neg: got %h sat %b want %h sat 0", prod_a, sat_a,
                        pk24x4(2916352, 2457600, 1638400, 589824));
    end
  endtask

  task automatic test_round();
    logic r0, v1, v2;
    run_beat(3, 1'b0, r0, v1, v2);
    n_cmp++;
    if (prod_b !== pk24x4(67, 56, 38, 14)) begin
      n_bad++; $display("FAIL round_pos: got %h want %h", prod_b, pk24x4(67, 56, 38, 14));
    end
    run_beat(3, 1'b1, r0, v1, v2);
    n_cmp++;
    if (prod_b !== pk24x4(-67, -56, -37, -13) || sat_b !== 1'b0) begin
      n_bad++; $display("FAIL round_neg: got %h sat %b want %h sat 0", prod_b, sat_b,
                        pk24x4(-67, -56, -37, -13));
    end
  endtask

  task automatic test_saturate();
    logic r0, v1, v2;
    run_beat(1000, 1'b0, r0, v1, v2);
    n_cmp++;
    if (prod_c !== pk16x4(32767, 32767, 32767, 18000) || sat_c !== 1'b1) begin
      n_bad++; $display("FAIL sat_pos: got %h sat %b want %h sat 1", prod_c, sat_c,
                        pk16x4(32767, 32767, 32767, 18000));
    end
    n_cmp++;
    if (prod_a !== pk24x4(89000, 75000, 50000, 18000) || sat_a !== 1'b0) begin
      n_bad++; $display("FAIL sat_wide: got %h sat %b want %h sat 0", prod_a, sat_a,
                        pk24x4(89000, 75000, 50000, 18000));
    end
    run_beat(-1000, 1'b0, r0, v1, v2);
    n_cmp++;
    if (prod_c !== pk16x4(-32768, -32768, -32768, -18000) || sat_c !== 1'b1) begin
      n_bad++; $display("FAIL sat_neg: got %h sat %b want %h sat 1", prod_c, sat_c,
                        pk16x4(-32768, -32768, -32768, -18000));
    end
  endtask

  task automatic test_back_to_back();
    int          sent = 0;
    int          got = 0;
    int          inflight = 0;
    int          cyc = 0;
    logic        prev_stall = 1'b0;
    logic [95:0] prev_prod = '0;
    logic        exp_rdy, acc_in, acc_out;
    logic [95:0] exp_prod;
    while (got < 10 && cyc < 400) begin
      @(negedge HCLK);
      cyc++;
      if (prev_stall) begin
        n_cmp++;
        if (vld_a !== 1'b1 || prod_a !== prev_prod) begin
          n_bad++; $display("FAIL b2b_hold: got v=%b %h want v=1 %h", vld_a, prod_a, prev_prod);
        end
      end
      in_valid  = (sent < 10);
      in_val    = 16'(sent);
      in_neg    = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = !(inflight == 2 && !out_ready);
      n_cmp++;
      if (rdy_a !== exp_rdy) begin
        n_bad++; $display("FAIL b2b_ready: got %b want %b (inflight %0d)", rdy_a, exp_rdy,
                          inflight);
      end
      acc_in  = in_valid && rdy_a;
      acc_out = vld_a && out_ready;
      if (acc_out) begin
        exp_prod = pk24x4(89 * got, 75 * got, 50 * got, 18 * got);
        n_cmp++;
        if (prod_a !== exp_prod) begin
          n_bad++; $display("FAIL b2b_data: beat %0d got %h want %h", got, prod_a, exp_prod);
        end
        got++;
      end
      if (acc_in) sent++;
      inflight   = inflight + int'(acc_in) - int'(acc_out);
      prev_stall = vld_a && !out_ready;
      prev_prod  = prod_a;
    end
    n_cmp++;
    if (got != 10) begin
      n_bad++; $display("FAIL b2b_timeout: got %0d beats want 10", got);
    end
    @(negedge HCLK);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge HCLK);
  endtask

  task automatic test_reset_midstream();
    logic r0, v1, v2;
    out_ready = 1'b0;
    @(negedge HCLK);
    in_valid = 1'b1;
    in_val   = 16'd5;
    in_neg   = 1'b0;
    #1;
    n_cmp++;
    if (rdy_a !== 1'b1) begin
      n_bad++; $display("FAIL mid_fill0: got in_ready %b want 1", rdy_a);
    end
    @(negedge HCLK);
    in_val = 16'd6;
    #1;
    n_cmp++;
    if (rdy_a !== 1'b1) begin
      n_bad++; $display("FAIL mid_fill1: got in_ready %b want 1", rdy_a);
    end
    @(negedge HCLK);
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (rdy_a !== 1'b0 || vld_a !== 1'b1 || prod_a !== pk24x4(445, 375, 250, 90)) begin
      n_bad++; $display("FAIL mid_full: got rdy %b v %b %h want rdy 0 v 1 %h", rdy_a, vld_a,
                        prod_a, pk24x4(445, 375, 250, 90));
    end
    #2 HRESETn = 1'b0;
    #1;
    n_cmp++;
    if (vld_a !== 1'b0 || prod_a !== '0 || sat_a !== 1'b0 || prod_d !== '0) begin
      n_bad++; $display("FAIL mid_async: got v %b %h sat %b want v 0 prod 0 sat 0", vld_a,
                        prod_a, sat_a);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    run_beat(7, 1'b0, r0, v1, v2);
    n_cmp++;
    if ({r0, v1, v2} !== 3'b101 || prod_a !== pk24x4(623, 525, 350, 126)) begin
      n_bad++; $display("FAIL mid_after: got rdy/v1/v2=%b %h want 101 %h", {r0, v1, v2},
                        prod_a, pk24x4(623, 525, 350, 126));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_input();
    test_round();
    test_saturate();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
